// File: rtl/fpu_cu_pkg.sv
// Shared types and constants for the FPU sequencing control unit.
package fpu_cu_pkg;

   // Controller states
   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StWait,
      StDone,
      StErr
   } state_e;

   // err_code values
   localparam logic [1:0] ErrNone        = 2'd0;
   localparam logic [1:0] ErrOpcode      = 2'd1;
   localparam logic [1:0] ErrLoadTimeout = 2'd2;
   localparam logic [1:0] ErrUnitTimeout = 2'd3;

   // Fixed unit indices; higher indices are free for other units
   localparam int unsigned OpDiv  = 0;
   localparam int unsigned OpSqrt = 1;

   // Minimum-wait counter width, enough for MIN_WAIT up to 15
   localparam int unsigned WaitCntW = 4;

   // Width of a counter that must be able to hold the value t
   function automatic int unsigned timer_width(input int unsigned t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/fpu_cu_timer.sv
// Clearable, saturating cycle counter. tc_o flags the last permitted cycle, so the
// owner leaves its state after exactly TIMEOUT cycles of residence.
module fpu_cu_timer
   import fpu_cu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CntW    = timer_width(TIMEOUT)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(TIMEOUT);
   localparam logic [CntW-1:0] TcCnt  = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   // Clear has priority; otherwise count up and hold at TIMEOUT rather than wrap
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != MaxCnt)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q >= TcCnt);

endmodule

// File: rtl/fpu_seq_cu.sv
// Sequencing control unit for a set of multi-cycle FPU arithmetic units (div, sqrt, ...).
// Loads operands, fires a one-hot start pulse, waits for the selected unit's done,
// and reports illegal opcodes and load/unit timeouts through a sticky error state.
module fpu_seq_cu
   import fpu_cu_pkg::*;
#(
   parameter int unsigned NUM_OPS  = 4,
   parameter int unsigned OP_W     = 2,
   parameter int unsigned MIN_WAIT = 3,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [OP_W-1:0]    opcode_i,
   input  logic               operation_ready_i,
   input  logic [NUM_OPS-1:0] unit_done_i,
   input  logic               abort_i,
   input  logic               clr_err_i,
   output logic               operation_load_o,
   output logic [NUM_OPS-1:0] unit_start_o,
   output logic               ready_o,
   output logic               done_o,
   output logic               err_o,
   output logic [1:0]         err_code_o,
   output logic [OP_W-1:0]    active_op_o
);

   localparam logic [WaitCntW-1:0] MinWait = WaitCntW'(MIN_WAIT);

   state_e               state_d, state_q;
   logic [OP_W-1:0]      active_op_d, active_op_q;
   logic [1:0]           err_code_d, err_code_q;
   logic [WaitCntW-1:0]  wait_cnt_d, wait_cnt_q;
   logic [NUM_OPS-1:0]   op_mask;
   logic                 opcode_legal;
   logic                 sel_done;
   logic                 wait_open;
   logic                 tmr_clr;
   logic                 tmr_en;
   logic                 tmr_tc;

   // One-hot decode of the captured opcode; used for both start and done selection
   always_comb begin
      op_mask = '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
         op_mask[i] = (active_op_q == OP_W'(i));
      end
   end

   // Only the active unit's done bit is ever looked at
   assign sel_done     = |(unit_done_i & op_mask);
   assign opcode_legal = (32'(opcode_i) < NUM_OPS);
   assign wait_open    = (wait_cnt_q == '0);

   // Next-state logic; abort beats timeout, timeout beats normal progress
   always_comb begin
      state_d     = state_q;
      active_op_d = active_op_q;
      err_code_d  = err_code_q;
      wait_cnt_d  = wait_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (opcode_legal) begin
                  state_d     = StLoad;
                  active_op_d = opcode_i;
               end else begin
                  state_d    = StErr;
                  err_code_d = ErrOpcode;
               end
            end
         end

         StLoad: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (tmr_tc) begin
               state_d    = StErr;
               err_code_d = ErrLoadTimeout;
            end else if (operation_ready_i) begin
               state_d = StRun;
            end
         end

         StRun: begin
            if (abort_i) begin
               state_d = StIdle;
            end else begin
               state_d    = StWait;
               wait_cnt_d = MinWait;
            end
         end

         StWait: begin
            // Masking window counts down and sticks at zero
            if (!wait_open) begin
               wait_cnt_d = wait_cnt_q - WaitCntW'(1);
            end
            if (abort_i) begin
               state_d = StIdle;
            end else if (tmr_tc) begin
               state_d    = StErr;
               err_code_d = ErrUnitTimeout;
            end else if (wait_open && sel_done && operation_ready_i) begin
               state_d = StDone;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         StErr: begin
            if (clr_err_i) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // IDLE always presents a clean slate
      if (state_d == StIdle) begin
         active_op_d = '0;
         err_code_d  = ErrNone;
         wait_cnt_d  = '0;
      end
   end

   // Timeout counter restarts on every state change and only runs in LOAD and WAIT
   assign tmr_clr = (state_d != state_q);
   assign tmr_en  = (state_q == StLoad) || (state_q == StWait);

   fpu_cu_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .tc_o   (tmr_tc)
   );

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         active_op_q <= '0;
         err_code_q  <= ErrNone;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         active_op_q <= active_op_d;
         err_code_q  <= err_code_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   // Moore output decode
   always_comb begin
      ready_o          = (state_q == StIdle);
      operation_load_o = (state_q == StLoad);
      unit_start_o     = (state_q == StRun) ? op_mask : '0;
      done_o           = (state_q == StDone);
      err_o            = (state_q == StErr);
   end

   assign err_code_o  = err_code_q;
   assign active_op_o = active_op_q;

endmodule
